// File: rtl/ctr_pkg.sv
// Shared defaults and legal-range limits for the modulo-N counter family.
package ctr_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int MODULUS_DEF = 10;
  localparam int PRESC_DEF   = 1;

  localparam int WIDTH_MIN   = 1;
  localparam int WIDTH_MAX   = 16;
  localparam int MODULUS_MIN = 2;
  localparam int PRESC_MIN   = 1;

  // True when a WIDTH/MODULUS/PRESC combination can be built.
  function automatic bit params_ok(input int w, input int m, input int p);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX) &&
           (m >= MODULUS_MIN) && (m <= (1 << w)) &&
           (p >= PRESC_MIN);
  endfunction

endpackage

// File: rtl/ctr_mod_n_ce_prescaler.sv
// Clock-enable prescaler: TICK marks the last of every PRESC qualified cycles.
module ce_prescaler
  import ctr_pkg::*;
#(
  parameter int PRESC = PRESC_DEF
) (
  input  logic C1K,
  input  logic RST,
  input  logic CE,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

  if (PRESC < PRESC_MIN) begin : g_bad_presc
    $error("ce_prescaler: PRESC must be >= %0d", PRESC_MIN);
  end

  logic [CW-1:0] cnt;

  // With PRESC=1 the count sits at 0 == LAST, so TICK stays high.
  assign TICK = (cnt == LAST);

  // Phase counter: advances only on qualified cycles, CLR restarts the period.
  always_ff @(posedge C1K or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (CLR) begin
      cnt <= '0;
    end else if (CE) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ctr_mod_n.sv
// Modulo-N up/down counter with load clamp, saturate/wrap mode, prescaled
// enable, cascade carry and sticky limit flag.
module ctr_mod_n
  import ctr_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MODULUS = MODULUS_DEF,
  parameter int PRESC   = PRESC_DEF
) (
  input  logic             C1K,
  input  logic             RST,
  input  logic             CE,
  input  logic             UP,
  input  logic             SAT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LDVAL,
  output logic [WIDTH-1:0] VAL,
  output logic             TC,
  output logic             CO,
  output logic             OVF
);

  if (!params_ok(WIDTH, MODULUS, PRESC)) begin : g_bad_param
    $error("ctr_mod_n: illegal WIDTH=%0d MODULUS=%0d PRESC=%0d", WIDTH, MODULUS, PRESC);
  end

  localparam logic [WIDTH-1:0] VMAX    = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic tick;
  logic step;

  ce_prescaler #(.PRESC(PRESC)) u_presc (
    .C1K  (C1K),
    .RST  (RST),
    .CE   (CE),
    .CLR  (LOAD),
    .TICK (tick)
  );

  assign step = CE & tick;

  // Terminal count follows the live direction input, no pipelining.
  assign TC = UP ? (VAL == VMAX) : (VAL == '0);
  assign CO = TC & step & ~SAT;

  // Count register and sticky flag: load beats step, step beats hold.
  always_ff @(posedge C1K or negedge RST) begin
    if (!RST) begin
      VAL <= '0;
      OVF <= 1'b0;
    end else if (LOAD) begin
      VAL <= ({1'b0, LDVAL} >= MOD_EXT) ? VMAX : LDVAL;
      OVF <= 1'b0;
    end else if (step) begin
      if (TC) begin
        if (SAT) begin
          OVF <= 1'b1;
        end else begin
          VAL <= UP ? '0 : VMAX;
        end
      end else begin
        VAL <= UP ? VAL + WIDTH'(1) : VAL - WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ctr_mod_n.sv
// Bench for ctr_mod_n: directed scenarios plus random traffic against a
// modular-arithmetic reference model.
module tb_ctr_mod_n;

  localparam int M = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce, up, sat, load;
  logic [3:0] ldval;

  logic [3:0] val_a, val_p, val_lo, val_hi;
  logic       tc_a, co_a, ovf_a;
  logic       tc_p, co_p, ovf_p;
  logic       tc_lo, co_lo, ovf_lo;
  logic       tc_hi, co_hi, ovf_hi;

  always #5 clk = ~clk;

  ctr_mod_n #(.WIDTH(4), .MODULUS(10), .PRESC(1)) u_a (
    .C1K(clk), .RST(rst), .CE(ce), .UP(up), .SAT(sat), .LOAD(load),
    .LDVAL(ldval), .VAL(val_a), .TC(tc_a), .CO(co_a), .OVF(ovf_a));

  ctr_mod_n #(.WIDTH(4), .MODULUS(10), .PRESC(3)) u_p (
    .C1K(clk), .RST(rst), .CE(ce), .UP(up), .SAT(sat), .LOAD(load),
    .LDVAL(ldval), .VAL(val_p), .TC(tc_p), .CO(co_p), .OVF(ovf_p));

  ctr_mod_n #(.WIDTH(4), .MODULUS(10), .PRESC(1)) u_lo (
    .C1K(clk), .RST(rst), .CE(ce), .UP(up), .SAT(sat), .LOAD(load),
    .LDVAL(ldval), .VAL(val_lo), .TC(tc_lo), .CO(co_lo), .OVF(ovf_lo));

  ctr_mod_n #(.WIDTH(4), .MODULUS(10), .PRESC(1)) u_hi (
    .C1K(clk), .RST(rst), .CE(co_lo), .UP(up), .SAT(sat), .LOAD(load),
    .LDVAL(ldval), .VAL(val_hi), .TC(tc_hi), .CO(co_hi), .OVF(ovf_hi));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model for u_a (index 0) and u_p (index 1): value, qualified
  // cycles since last step, sticky flag.
  int pr[2] = '{1, 3};
  int mv[2];
  int mq[2];
  bit mo[2];

  function automatic bit m_tick(input int i);
    return mq[i] == pr[i] - 1;
  endfunction

  function automatic bit m_tc(input int i);
    return up ? (mv[i] == M - 1) : (mv[i] == 0);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mq[i] = 0; mo[i] = 1'b0;
    end
  endtask

  task automatic m_edge(input int i);
    int nxt;
    bit crossed;
    if (load) begin
      mv[i] = (int'(ldval) >= M) ? M - 1 : int'(ldval);
      mq[i] = 0;
      mo[i] = 1'b0;
    end else if (ce) begin
      if (m_tick(i)) begin
        nxt = (mv[i] + (up ? 1 : M - 1)) % M;
        crossed = up ? (nxt == 0) : (nxt == M - 1);
        if (crossed && sat) mo[i] = 1'b1;
        else mv[i] = nxt;
        mq[i] = 0;
      end else begin
        mq[i] = mq[i] + 1;
      end
    end
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic cycle();
    #1;
    if (!rst) m_reset();
    chk("tc_a", tc_a, m_tc(0));
    chk("co_a", co_a, m_tc(0) & ce & m_tick(0) & ~sat);
    chk("tc_p", tc_p, m_tc(1));
    chk("co_p", co_p, m_tc(1) & ce & m_tick(1) & ~sat);
    if (rst) begin
      m_edge(0);
      m_edge(1);
    end
    @(posedge clk);
    #1;
    chk("val_a", val_a, mv[0]);
    chk("ovf_a", ovf_a, mo[0]);
    chk("val_p", val_p, mv[1]);
    chk("ovf_p", ovf_p, mo[1]);
  endtask

  task automatic drive(input bit c, input bit u, input bit s, input bit l, input int lv);
    ce = c; up = u; sat = s; load = l; ldval = 4'(lv);
  endtask

  // Assert reset between edges and confirm it acts without a clock.
  task automatic async_rst(input string tag);
    #3;
    rst = 1'b0;
    #1;
    chk({tag, "_val"}, val_a, 0);
    chk({tag, "_ovf"}, ovf_a, 0);
    m_reset();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    m_reset();
    #12;
    chk("rst_val", val_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_val_p", val_p, 0);
    rst = 1'b1;

    // Up-count wrap with carry only while VAL=9.
    drive(1, 1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("up_val", val_a, k % M);
      chk("up_co", co_a, (k % M) == 9);
    end

    // Down step from 0 wraps to 9, then saturate, then load clears flag.
    drive(1, 1, 0, 1, 0);
    cycle();
    drive(1, 0, 0, 0, 0);
    cycle();
    chk("dn_wrap", val_a, 9);
    drive(1, 1, 1, 0, 0);
    cycle();
    chk("sat_val", val_a, 9);
    chk("sat_ovf", ovf_a, 1);
    chk("sat_co", co_a, 0);
    cycle();
    chk("sat_hold", val_a, 9);
    async_rst("rst_ovf");
    drive(1, 1, 1, 1, 9);
    cycle();
    drive(1, 1, 1, 0, 0);
    cycle();
    chk("sat_ovf2", ovf_a, 1);
    drive(1, 1, 1, 1, 3);
    cycle();
    chk("ld_val", val_a, 3);
    chk("ld_ovf", ovf_a, 0);

    // Load clamp beats a concurrent step.
    drive(1, 1, 0, 1, 12);
    cycle();
    chk("clamp12", val_a, 9);
    drive(1, 1, 0, 1, 15);
    cycle();
    chk("clamp15", val_a, 9);

    // Prescaler: step every 3rd qualified edge, CE gaps stretch the period.
    drive(1, 1, 0, 1, 0);
    cycle();
    drive(1, 1, 0, 0, 0);
    cycle();
    cycle();
    chk("presc_wait", val_p, 0);
    cycle();
    chk("presc_step", val_p, 1);
    cycle();
    drive(0, 1, 0, 0, 0);
    cycle();
    cycle();
    drive(1, 1, 0, 0, 0);
    cycle();
    chk("presc_gap", val_p, 1);
    cycle();
    chk("presc_ext", val_p, 2);

    // Async reset at VAL=7, then first increment after release.
    drive(0, 1, 0, 1, 7);
    cycle();
    drive(0, 1, 0, 0, 0);
    chk("pre_rst7", val_a, 7);
    async_rst("rst7");
    drive(1, 1, 0, 0, 0);
    cycle();
    chk("post_rst", val_a, 1);

    // Cascade: low CO enables high counter.
    async_rst("rst_casc");
    drive(1, 1, 0, 0, 0);
    for (int k = 0; k < 25; k++) cycle();
    chk("casc_hi", val_hi, 2);
    chk("casc_lo", val_lo, 5);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) != 0);
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)));
      cycle();
      chk("range_a", val_a < 4'(M), 1);
    end
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
